// File: rtl/serial_negate_ctrl.sv
// Bit-serial two's-complement negate/pass unit with valid/ready handshakes.
// One operand is in flight at a time: IDLE accepts, SHIFT runs WIDTH cycles LSB first, DONE holds the result.
module serial_negate_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             seen_one;
    logic             neg;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] oreg;
    logic             ovf;
    logic             cur_bit;
    logic             res_bit;

    assign cur_bit = sreg[0];
    assign res_bit = (neg & seen_one) ? ~cur_bit : cur_bit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            seen_one <= 1'b0;
            neg      <= 1'b0;
            sreg     <= '0;
            oreg     <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sreg     <= in_data;
                        neg      <= in_neg;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                        oreg     <= '0;
                        ovf      <= 1'b0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sreg     <= sreg >> 1;
                    oreg     <= {res_bit, oreg[WIDTH-1:1]};
                    seen_one <= seen_one | cur_bit;
                    if (cnt == LAST) begin
                        // MSB set with no lower one seen means the operand is the most-negative value
                        ovf   <= neg & cur_bit & ~seen_one;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_data  = (state == S_DONE) ? oreg : '0;
    assign out_ovf   = (state == S_DONE) & ovf;

endmodule
